// File: rtl/ssd_scan_driver_if.sv
// Stopwatch-to-display bundle for ssd_scan_driver.
// master = the stopwatch side (drives digit values), slave = the scan driver.
interface ssd_scan_driver_if;
  logic       i_Enable;
  logic [3:0] i_Digit_1_val;
  logic [3:0] i_Digit_2_val;
  logic [3:0] i_Digit_3_val;
  logic [3:0] i_Digit_4_val;
  logic [3:0] i_DP;
  logic [3:0] o_Anode;
  logic [6:0] o_Cathode;
  logic       o_DP;
  logic       o_Frame_Tick;

  modport master (
    output i_Enable, i_Digit_1_val, i_Digit_2_val, i_Digit_3_val, i_Digit_4_val, i_DP,
    input  o_Anode, o_Cathode, o_DP, o_Frame_Tick
  );

  modport slave (
    input  i_Enable, i_Digit_1_val, i_Digit_2_val, i_Digit_3_val, i_Digit_4_val, i_DP,
    output o_Anode, o_Cathode, o_DP, o_Frame_Tick
  );
endinterface

// File: rtl/ssd_scan_driver.sv
// Time-multiplexed driver for a 4-digit common-anode seven-segment display.
// Each digit slot is c_REFRESH_DIV cycles: c_BLANK_CYCLES dark, then lit.
// Digit values are snapshotted at each frame start so a frame never tears.
// Optional macro SSD_LEADING_ZERO_BLANK_EN suppresses leading zero digits 1-3.
module ssd_scan_driver #(
  parameter int c_REFRESH_DIV  = 100000,
  parameter int c_BLANK_CYCLES = 1000
) (
  input logic i_CLK,
  input logic i_RST_N,
  ssd_scan_driver_if.slave bus
);

  localparam int CNT_W = (c_REFRESH_DIV > 1) ? $clog2(c_REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST_COUNT  = CNT_W'(c_REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] TICK_PREV   = CNT_W'(c_REFRESH_DIV - 2);
  localparam logic [CNT_W-1:0] BLANK_LAST  = CNT_W'(c_BLANK_CYCLES - 1);
  localparam logic             SHOW_IS_ONE = (c_BLANK_CYCLES == c_REFRESH_DIV - 1);

  typedef enum logic [1:0] {
    ST_OFF,
    ST_BLANK,
    ST_SHOW
  } state_t;

  state_t           state;
  logic [1:0]       slot;
  logic [CNT_W-1:0] count;
  logic [3:0]       snap_digit [4];
  logic [3:0]       snap_dp;
  logic             take_snap;
  logic [3:0]       suppress;
  logic [3:0]       show_anode;
  logic [6:0]       show_cathode;
  logic             show_dp;

  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    case (v)
      4'h0: seg_decode = 7'b1000000;
      4'h1: seg_decode = 7'b1111001;
      4'h2: seg_decode = 7'b0100100;
      4'h3: seg_decode = 7'b0110000;
      4'h4: seg_decode = 7'b0011001;
      4'h5: seg_decode = 7'b0010010;
      4'h6: seg_decode = 7'b0000010;
      4'h7: seg_decode = 7'b1111000;
      4'h8: seg_decode = 7'b0000000;
      4'h9: seg_decode = 7'b0010000;
      4'hA: seg_decode = 7'b0001000;
      4'hB: seg_decode = 7'b0000011;
      4'hC: seg_decode = 7'b1000110;
      4'hD: seg_decode = 7'b0100001;
      4'hE: seg_decode = 7'b0000110;
      default: seg_decode = 7'b0001110;
    endcase
  endfunction

  // Snapshot at frame start: leaving OFF, or wrapping from the last cycle of slot 3.
  always_comb begin
    take_snap = bus.i_Enable &&
                ((state == ST_OFF) ||
                 (state == ST_SHOW && count == LAST_COUNT && slot == 2'd3));
  end

  // Leading-zero mask over the snapshot; digit 4 (slot 3) is never suppressed.
  always_comb begin
    suppress = 4'b0000;
`ifdef SSD_LEADING_ZERO_BLANK_EN
    suppress[0] = (snap_digit[0] == 4'h0);
    suppress[1] = suppress[0] && (snap_digit[1] == 4'h0);
    suppress[2] = suppress[1] && (snap_digit[2] == 4'h0);
`endif
  end

  // What the current slot shows once its dark period ends.
  always_comb begin
    show_anode   = suppress[slot] ? 4'b1111 : ~(4'b1000 >> slot);
    show_cathode = suppress[slot] ? 7'b1111111 : seg_decode(snap_digit[slot]);
    show_dp      = ~snap_dp[2'd3 - slot];
  end

  // Frame snapshot registers.
  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      for (int i = 0; i < 4; i++) snap_digit[i] <= 4'h0;
      snap_dp <= 4'h0;
    end else if (take_snap) begin
      snap_digit[0] <= bus.i_Digit_1_val;
      snap_digit[1] <= bus.i_Digit_2_val;
      snap_digit[2] <= bus.i_Digit_3_val;
      snap_digit[3] <= bus.i_Digit_4_val;
      snap_dp       <= bus.i_DP;
    end
  end

  // Scan FSM: slot/cycle counters and registered display outputs.
  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      state            <= ST_OFF;
      slot             <= 2'd0;
      count            <= '0;
      bus.o_Anode      <= 4'b1111;
      bus.o_Cathode    <= 7'b1111111;
      bus.o_DP         <= 1'b1;
      bus.o_Frame_Tick <= 1'b0;
    end else if (!bus.i_Enable) begin
      state            <= ST_OFF;
      slot             <= 2'd0;
      count            <= '0;
      bus.o_Anode      <= 4'b1111;
      bus.o_Cathode    <= 7'b1111111;
      bus.o_DP         <= 1'b1;
      bus.o_Frame_Tick <= 1'b0;
    end else begin
      case (state)
        ST_OFF: begin
          state            <= ST_BLANK;
          slot             <= 2'd0;
          count            <= '0;
          bus.o_Anode      <= 4'b1111;
          bus.o_Cathode    <= 7'b1111111;
          bus.o_DP         <= 1'b1;
          bus.o_Frame_Tick <= 1'b0;
        end
        ST_BLANK: begin
          count <= count + 1'b1;
          if (count == BLANK_LAST) begin
            state            <= ST_SHOW;
            bus.o_Anode      <= show_anode;
            bus.o_Cathode    <= show_cathode;
            bus.o_DP         <= show_dp;
            bus.o_Frame_Tick <= SHOW_IS_ONE && (slot == 2'd3);
          end
        end
        ST_SHOW: begin
          if (count == LAST_COUNT) begin
            state            <= ST_BLANK;
            count            <= '0;
            slot             <= slot + 2'd1;
            bus.o_Anode      <= 4'b1111;
            bus.o_Cathode    <= 7'b1111111;
            bus.o_DP         <= 1'b1;
            bus.o_Frame_Tick <= 1'b0;
          end else begin
            count            <= count + 1'b1;
            bus.o_Frame_Tick <= (slot == 2'd3) && (count == TICK_PREV);
          end
        end
        default: begin
          state            <= ST_OFF;
          slot             <= 2'd0;
          count            <= '0;
          bus.o_Anode      <= 4'b1111;
          bus.o_Cathode    <= 7'b1111111;
          bus.o_DP         <= 1'b1;
          bus.o_Frame_Tick <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Self-checking bench for ssd_scan_driver (c_REFRESH_DIV = 8, c_BLANK_CYCLES = 2).
// Per-cycle expected outputs are queued when a frame is started and popped on negedges.
module tb_ssd_scan_driver;

  localparam int c_DIV   = 8;
  localparam int c_BLANK = 2;

  typedef struct packed {
    logic [3:0] anode;
    logic [6:0] cath;
    logic       dp;
    logic       tick;
  } exp_t;

  typedef struct {
    logic [3:0]      d1, d2, d3, d4;
    logic [3:0]      dp;
    logic [3:0][6:0] cath;
    logic [3:0]      lit;
  } vec_t;

  logic w_SUBCLK = 1'b0;
  logic w_RST    = 1'b0;

  ssd_scan_driver_if bus();

  ssd_scan_driver #(
    .c_REFRESH_DIV (c_DIV),
    .c_BLANK_CYCLES(c_BLANK)
  ) dut (
    .i_CLK  (w_SUBCLK),
    .i_RST_N(w_RST),
    .bus    (bus)
  );

  always #5 w_SUBCLK = ~w_SUBCLK;

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];
  vec_t vecs[6];
  exp_t dark;

  function automatic vec_t mkVec(input logic [3:0] a, input logic [3:0] b,
                                 input logic [3:0] c, input logic [3:0] d,
                                 input logic [3:0] dp,
                                 input logic [6:0] ca, input logic [6:0] cb,
                                 input logic [6:0] cc, input logic [6:0] cd,
                                 input logic [3:0] lit);
    vec_t v;
    v.d1 = a; v.d2 = b; v.d3 = c; v.d4 = d; v.dp = dp;
    v.cath[0] = ca; v.cath[1] = cb; v.cath[2] = cc; v.cath[3] = cd;
    v.lit = lit;
    return v;
  endfunction

  task automatic checkOutput(input string name, input exp_t want);
    exp_t got;
    got.anode = bus.o_Anode;
    got.cath  = bus.o_Cathode;
    got.dp    = bus.o_DP;
    got.tick  = bus.o_Frame_Tick;
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got anode=%b cathode=%b dp=%b tick=%b, want anode=%b cathode=%b dp=%b tick=%b",
               name, got.anode, got.cath, got.dp, got.tick,
               want.anode, want.cath, want.dp, want.tick);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input logic en);
    bus.i_Digit_1_val = v.d1;
    bus.i_Digit_2_val = v.d2;
    bus.i_Digit_3_val = v.d3;
    bus.i_Digit_4_val = v.d4;
    bus.i_DP          = v.dp;
    bus.i_Enable      = en;
  endtask

  // Queue one full frame (4 slots x c_DIV cycles) of expected outputs.
  task automatic pushFrame(input vec_t v);
    exp_t e;
    for (int s = 0; s < 4; s++) begin
      for (int c = 0; c < c_DIV; c++) begin
        e = dark;
        if (c >= c_BLANK) begin
          if (v.lit[s]) begin
            e.anode = ~(4'b1000 >> s);
            e.cath  = v.cath[s];
          end
          e.dp   = ~v.dp[3-s];
          e.tick = (s == 3) && (c == c_DIV - 1);
        end
        sb.push_back(e);
      end
    end
  endtask

  task automatic drainQueue(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge w_SUBCLK);
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL %s[%0d]: scoreboard empty, required an entry", name, i);
      end else begin
        checkOutput($sformatf("%s[%0d]", name, i), sb.pop_front());
      end
    end
  endtask

  initial begin
    vec_t v2;
    dark.anode = 4'b1111;
    dark.cath  = 7'b1111111;
    dark.dp    = 1'b1;
    dark.tick  = 1'b0;

    vecs[0] = mkVec(4'h1, 4'h2, 4'h3, 4'h4, 4'b0000,
                    7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 4'b1111);
    vecs[1] = mkVec(4'hA, 4'hB, 4'hC, 4'hF, 4'b0010,
                    7'b0001000, 7'b0000011, 7'b1000110, 7'b0001110, 4'b1111);
    vecs[3] = mkVec(4'h5, 4'h6, 4'h8, 4'h9, 4'b1001,
                    7'b0010010, 7'b0000010, 7'b0000000, 7'b0010000, 4'b1111);
    vecs[5] = mkVec(4'hE, 4'hD, 4'h0, 4'h0, 4'b0000,
                    7'b0000110, 7'b0100001, 7'b1000000, 7'b1000000, 4'b1111);
`ifdef SSD_LEADING_ZERO_BLANK_EN
    vecs[2] = mkVec(4'h0, 4'h0, 4'h7, 4'h0, 4'b0000,
                    7'b1000000, 7'b1000000, 7'b1111000, 7'b1000000, 4'b1100);
    vecs[4] = mkVec(4'h0, 4'h0, 4'h0, 4'h0, 4'b0100,
                    7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000, 4'b1000);
`else
    vecs[2] = mkVec(4'h0, 4'h0, 4'h7, 4'h0, 4'b0000,
                    7'b1000000, 7'b1000000, 7'b1111000, 7'b1000000, 4'b1111);
    vecs[4] = mkVec(4'h0, 4'h0, 4'h0, 4'h0, 4'b0100,
                    7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000, 4'b1111);
`endif

    applyStimulus(vecs[0], 1'b0);
    w_RST = 1'b0;
    repeat (3) @(negedge w_SUBCLK);
    checkOutput("reset", dark);
    w_RST = 1'b1;
    @(negedge w_SUBCLK);
    checkOutput("idle_off", dark);

    $display("[TB] table vectors");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i], 1'b1);
      pushFrame(vecs[i]);
      drainQueue($sformatf("vec%0d", i), 4 * c_DIV);
      bus.i_Enable = 1'b0;
      @(negedge w_SUBCLK);
      checkOutput($sformatf("vec%0d_disable", i), dark);
    end

    $display("[TB] mid-frame input change");
    applyStimulus(vecs[0], 1'b1);
    pushFrame(vecs[0]);
    drainQueue("snap_a", 12);
    bus.i_Digit_4_val = 4'h9;
    drainQueue("snap_a_rest", 4 * c_DIV - 12);
    v2 = vecs[0];
    v2.d4 = 4'h9;
    v2.cath[3] = 7'b0010000;
    pushFrame(v2);
    drainQueue("snap_b", 4 * c_DIV);

    $display("[TB] enable drop mid slot 2");
    pushFrame(v2);
    drainQueue("abort", 21);
    bus.i_Enable = 1'b0;
    sb.delete();
    sb.push_back(dark);
    sb.push_back(dark);
    drainQueue("abort_off", 2);
    applyStimulus(v2, 1'b1);
    pushFrame(v2);
    drainQueue("resume", 12);

    $display("[TB] async reset mid slot 1");
    #2;
    w_RST = 1'b0;
    #1;
    checkOutput("async_reset", dark);
    sb.delete();
    @(negedge w_SUBCLK);
    checkOutput("reset_held", dark);
    w_RST = 1'b1;
    pushFrame(v2);
    drainQueue("post_reset", 4 * c_DIV);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
